// File: rtl/axis_processor_arbiter.sv
// axis_processor_arbiter: shares one AXI-Stream processor among N_REQ requesters.
// Whole input packets are granted one at a time; each grant's requester ID is queued
// in a tag FIFO so processor output packets are routed back in grant order.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) and no rotating pointer is built.
module axis_processor_arbiter #(
    parameter int N_REQ     = 4,
    parameter int INP_WIDTH = 8,
    parameter int OUT_WIDTH = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*INP_WIDTH-1:0] s_axis_tdata,
    input  logic [N_REQ-1:0]           s_axis_tvalid,
    input  logic [N_REQ-1:0]           s_axis_tlast,
    output logic [N_REQ-1:0]           s_axis_tready,
    output logic [INP_WIDTH-1:0]       p_in_tdata,
    output logic                       p_in_tvalid,
    input  logic                       p_in_tready,
    input  logic [OUT_WIDTH-1:0]       p_out_tdata,
    input  logic                       p_out_tvalid,
    input  logic                       p_out_tlast,
    output logic                       p_out_tready,
    output logic [OUT_WIDTH-1:0]       m_axis_tdata,
    output logic [N_REQ-1:0]           m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic [N_REQ-1:0]           m_axis_tready
);
    localparam int TW = $clog2(N_REQ);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                          state_q, state_d;
    logic [TW-1:0]                   g_q, g_d;
    logic [TW-1:0]                   sel;
    logic                            found;
    logic [N_REQ-1:0][INP_WIDTH-1:0] s_data;

    logic [TW-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, in_eop;
    logic [TW-1:0] head;

    assign s_data = s_axis_tdata;
    assign full   = (count == CW'(TAG_DEPTH));
    assign empty  = (count == '0);
    assign head   = tag_mem[rd_ptr];

`ifdef ARB_ROUND_ROBIN_EN
    logic [TW-1:0] rr_ptr;
    logic [TW:0]   rr_sum;
    logic [TW-1:0] rr_idx;

    // Cyclic search for the first valid requester at or after rr_ptr.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_sum = '0;
        rr_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (TW+1)'(k);
            if (rr_sum >= (TW+1)'(N_REQ))
                rr_sum = rr_sum - (TW+1)'(N_REQ);
            rr_idx = rr_sum[TW-1:0];
            if (!found && s_axis_tvalid[rr_idx]) begin
                found = 1'b1;
                sel   = rr_idx;
            end
        end
    end

    // Rotate the search start past the requester whose packet just ended.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (in_eop)
            rr_ptr <= (g_q == TW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
    end
`else
    // Fixed priority: lowest-index valid requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && s_axis_tvalid[k]) begin
                found = 1'b1;
                sel   = TW'(k);
            end
        end
    end
`endif

    // Input FSM state and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    // Grant in IDLE, then pass the granted stream straight through until tlast.
    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        push          = 1'b0;
        in_eop        = 1'b0;
        s_axis_tready = '0;
        p_in_tvalid   = 1'b0;
        p_in_tdata    = '0;
        case (state_q)
            IDLE: begin
                if (found && !full) begin
                    g_d     = sel;
                    push    = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                p_in_tdata         = s_data[g_q];
                p_in_tvalid        = s_axis_tvalid[g_q];
                s_axis_tready[g_q] = p_in_tready;
                // A dropped valid keeps the lock; only a tlast handshake releases it.
                if (s_axis_tvalid[g_q] && p_in_tready && s_axis_tlast[g_q]) begin
                    in_eop  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= sel;
    end

    // Route processor output to the head tag; everything idles while the FIFO is empty.
    always_comb begin
        p_out_tready  = 1'b0;
        m_axis_tvalid = '0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        pop           = 1'b0;
        if (!empty) begin
            m_axis_tvalid[head] = p_out_tvalid;
            p_out_tready        = m_axis_tready[head];
            m_axis_tdata        = p_out_tdata;
            m_axis_tlast        = p_out_tlast;
            pop                 = p_out_tvalid && m_axis_tready[head] && p_out_tlast;
        end
    end
endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Self-checking bench for axis_processor_arbiter: scoreboard on both stream sides,
// a routing vector table, and directed multi-cycle sequences.
module tb_axis_processor_arbiter;
    localparam int NR = 4;
    localparam int IW = 8;
    localparam int OW = 8;
    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*IW-1:0]  s_axis_tdata;
    logic [NR-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [IW-1:0]     p_in_tdata;
    logic              p_in_tvalid, p_in_tready;
    logic [OW-1:0]     p_out_tdata;
    logic              p_out_tvalid, p_out_tlast, p_out_tready;
    logic [OW-1:0]     m_axis_tdata;
    logic [NR-1:0]     m_axis_tvalid, m_axis_tready;
    logic              m_axis_tlast;

    axis_processor_arbiter #(.N_REQ(NR), .INP_WIDTH(IW), .OUT_WIDTH(OW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .p_in_tdata(p_in_tdata), .p_in_tvalid(p_in_tvalid), .p_in_tready(p_in_tready),
        .p_out_tdata(p_out_tdata), .p_out_tvalid(p_out_tvalid),
        .p_out_tlast(p_out_tlast), .p_out_tready(p_out_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct { int req; logic [7:0] data; logic last; } beat_t;
    typedef struct {
        logic pv; logic [NR-1:0] mr; logic [7:0] d; logic lst;
        logic [NR-1:0] exp_mv; logic exp_pr; logic [7:0] exp_md; logic exp_ml;
    } rt_vec_t;

    beat_t exp_in[$];
    beat_t exp_out[$];
    int    beat_cyc[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    logic  mon_en = 1'b0;
    logic  mon_out_en = 1'b1;
    logic  done5 = 1'b0;
    logic  bp_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=%h required=<none> (t=%0t)", name, act, $time);
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int n, idx;
        n = 0; idx = 15;
        for (int i = 0; i < NR; i++) if (v[i]) begin n++; idx = i; end
        return (n == 1) ? idx : 15;
    endfunction

    function automatic logic [31:0] pk(input int r, input logic [7:0] d, input logic l);
        return {r[15:0], d, 7'b0, l};
    endfunction

    task automatic exp_i(input int r, input logic [7:0] d);
        beat_t b;
        b.req = r; b.data = d; b.last = 1'b0;
        exp_in.push_back(b);
    endtask

    task automatic exp_o(input int r, input logic [7:0] d, input logic l);
        beat_t b;
        b.req = r; b.data = d; b.last = l;
        exp_out.push_back(b);
    endtask

    task automatic exp_in_pkt(input int r, input int n, input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < n; k++) exp_i(r, base + 8'(k) * step);
    endtask

    task automatic exp_out_pkt(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) exp_o(r, base + 8'(k), k == n - 1);
    endtask

    // Scoreboard: compare every handshake against the head of the expected queues.
    beat_t mon_e;
    int    mon_r;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (p_in_tvalid && p_in_tready) begin
                beat_cyc.push_back(cyc);
                mon_r = oh_idx(s_axis_tready);
                if (exp_in.size() == 0) fail_now("in_unexpected_beat", pk(mon_r, p_in_tdata, 1'b0));
                else begin
                    mon_e = exp_in.pop_front();
                    check("in_beat", pk(mon_r, p_in_tdata, 1'b0), pk(mon_e.req, mon_e.data, 1'b0));
                end
            end
            if (mon_out_en && |(m_axis_tvalid & m_axis_tready)) begin
                mon_r = oh_idx(m_axis_tvalid);
                if (exp_out.size() == 0) fail_now("out_unexpected_beat", pk(mon_r, m_axis_tdata, m_axis_tlast));
                else begin
                    mon_e = exp_out.pop_front();
                    check("out_beat", pk(mon_r, m_axis_tdata, m_axis_tlast), pk(mon_e.req, mon_e.data, mon_e.last));
                end
            end
        end
    end

    // Requester driver: one packet, called and returning at posedge+1.
    task automatic send_pkt(input int req, input int n, input logic [7:0] base, input logic [7:0] step);
        int   k, waitc;
        logic hs;
        k = 0; waitc = 0;
        while (k < n) begin
            s_axis_tvalid[req]          = 1'b1;
            s_axis_tdata[req*IW +: IW]  = base + 8'(k) * step;
            s_axis_tlast[req]           = (k == n - 1);
            @(negedge clk);
            hs = s_axis_tvalid[req] && s_axis_tready[req];
            @(posedge clk); #1;
            if (hs) begin k++; waitc = 0; end
            else if (++waitc > 200) begin fail_now("send_timeout", 32'(req)); break; end
        end
        s_axis_tvalid[req] = 1'b0;
        s_axis_tlast[req]  = 1'b0;
    endtask

    // Processor-output driver: one packet with tlast on the last beat.
    task automatic recv_pkt(input int n, input logic [7:0] base);
        int   k, waitc;
        logic hs;
        k = 0; waitc = 0;
        while (k < n) begin
            p_out_tvalid = 1'b1;
            p_out_tdata  = base + 8'(k);
            p_out_tlast  = (k == n - 1);
            @(negedge clk);
            hs = p_out_tvalid && p_out_tready;
            @(posedge clk); #1;
            if (hs) begin k++; waitc = 0; end
            else if (++waitc > 200) begin fail_now("recv_timeout", 32'(k)); break; end
        end
        p_out_tvalid = 1'b0;
        p_out_tlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rt_vec_t tbl[5];
        int      c0;

        // Routing table, applied with tag 3 at the FIFO head; no entry pops.
        tbl[0] = '{1'b1, 4'b1000, 8'h5A, 1'b0, 4'b1000, 1'b1, 8'h5A, 1'b0};
        tbl[1] = '{1'b1, 4'b0111, 8'h3C, 1'b0, 4'b1000, 1'b0, 8'h3C, 1'b0};
        tbl[2] = '{1'b0, 4'b1111, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 4'b0000, 8'hFF, 1'b1, 4'b1000, 1'b0, 8'hFF, 1'b1};
        tbl[4] = '{1'b0, 4'b1000, 8'h77, 1'b1, 4'b0000, 1'b1, 8'h77, 1'b1};

        // Reset with busy-looking inputs; outputs must all be zero afterwards.
        rst = 1'b1;
        s_axis_tdata = 32'hA5C3_5A3C; s_axis_tvalid = '0; s_axis_tlast = '0;
        p_in_tready = 1'b1;
        p_out_tdata = 8'hEE; p_out_tvalid = 1'b1; p_out_tlast = 1'b1;
        m_axis_tready = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_s_tready", 32'(s_axis_tready), 0);
        check("rst_p_in_tvalid", 32'(p_in_tvalid), 0);
        check("rst_p_in_tdata", 32'(p_in_tdata), 0);
        check("rst_p_out_tready", 32'(p_out_tready), 0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_m_tdata", 32'(m_axis_tdata), 0);
        check("rst_m_tlast", 32'(m_axis_tlast), 0);
        @(posedge clk); #1;
        p_out_tvalid = 1'b0; p_out_tlast = 1'b0; p_out_tdata = '0;
        mon_en = 1'b1;

        // Single 3-beat packet from requester 2, 2-beat reply.
        exp_in_pkt(2, 3, 8'h11, 8'h11);
        exp_out_pkt(2, 2, 8'hA1);
        beat_cyc.delete();
        c0 = cyc;
        send_pkt(2, 3, 8'h11, 8'h11);
        check("sp_beat_count", 32'(beat_cyc.size()), 3);
        if (beat_cyc.size() == 3) begin
            check("sp_first_beat_cycle", 32'(beat_cyc[0] - c0), 1);
            check("sp_last_beat_cycle", 32'(beat_cyc[2] - c0), 3);
        end
        recv_pkt(2, 8'hA1);
        @(negedge clk);
        check("sp_fifo_empty_after", 32'(p_out_tready), 0);
        @(posedge clk); #1;

        // Routing vector table with requester 3 at the head.
        exp_i(3, 8'h33);
        send_pkt(3, 1, 8'h33, 8'h00);
        mon_out_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p_out_tvalid = tbl[i].pv; m_axis_tready = tbl[i].mr;
            p_out_tdata = tbl[i].d; p_out_tlast = tbl[i].lst;
            @(negedge clk);
            check($sformatf("rt%0d_m_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].exp_mv));
            check($sformatf("rt%0d_p_out_tready", i), 32'(p_out_tready), 32'(tbl[i].exp_pr));
            check($sformatf("rt%0d_m_tdata", i), 32'(m_axis_tdata), 32'(tbl[i].exp_md));
            check($sformatf("rt%0d_m_tlast", i), 32'(m_axis_tlast), 32'(tbl[i].exp_ml));
            @(posedge clk); #1;
        end
        p_out_tvalid = 1'b0; p_out_tlast = 1'b0; m_axis_tready = '1;
        mon_out_en = 1'b1;
        exp_out_pkt(3, 1, 8'h99);
        recv_pkt(1, 8'h99);

        // All four requesters contend with 1-beat packets; requester 0 sends two.
`ifdef ARB_ROUND_ROBIN_EN
        exp_i(0, 8'h40); exp_i(1, 8'h41); exp_i(2, 8'h42); exp_i(3, 8'h43); exp_i(0, 8'h50);
        exp_o(0, 8'hB0, 1); exp_o(1, 8'hB1, 1); exp_o(2, 8'hB2, 1); exp_o(3, 8'hB3, 1); exp_o(0, 8'hB4, 1);
`else
        exp_i(0, 8'h40); exp_i(0, 8'h50); exp_i(1, 8'h41); exp_i(2, 8'h42); exp_i(3, 8'h43);
        exp_o(0, 8'hB0, 1); exp_o(0, 8'hB1, 1); exp_o(1, 8'hB2, 1); exp_o(2, 8'hB3, 1); exp_o(3, 8'hB4, 1);
`endif
        beat_cyc.delete();
        fork
            begin send_pkt(0, 1, 8'h40, 8'h00); send_pkt(0, 1, 8'h50, 8'h00); end
            send_pkt(1, 1, 8'h41, 8'h00);
            send_pkt(2, 1, 8'h42, 8'h00);
            send_pkt(3, 1, 8'h43, 8'h00);
            for (int i = 0; i < 5; i++) recv_pkt(1, 8'hB0 + 8'(i));
        join
        check("arb_beat_count", 32'(beat_cyc.size()), 5);
        if (beat_cyc.size() == 5) begin
            check("arb_beat_spacing", 32'(beat_cyc[1] - beat_cyc[0]), 2);
            check("arb_total_span", 32'(beat_cyc[4] - beat_cyc[0]), 8);
        end

        // Full tag FIFO: four grants with no output drain, the fifth must wait.
        for (int r = 0; r < 4; r++) exp_i(r, 8'h60 + 8'(r));
        exp_i(0, 8'h68);
        for (int r = 0; r < 4; r++) send_pkt(r, 1, 8'h60 + 8'(r), 8'h00);
        done5 = 1'b0;
        fork
            begin send_pkt(0, 1, 8'h68, 8'h00); done5 = 1'b1; end
        join_none
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("full_blocked_%0d", i), {30'(0), p_in_tvalid, s_axis_tready[0]}, 0);
        end
        @(posedge clk); #1;
        exp_o(0, 8'hD0, 1);
        recv_pkt(1, 8'hD0);
        @(negedge clk);
        check("full_idle_after_pop", 32'(s_axis_tready), 0);
        @(negedge clk);
        check("full_fifth_granted", 32'(s_axis_tready), 32'b0001);
        for (int i = 0; i < 20 && !done5; i++) @(posedge clk);
        if (!done5) fail_now("full_fifth_timeout", 32'(cyc));
        @(posedge clk); #1;
        exp_o(1, 8'hD1, 1); exp_o(2, 8'hD2, 1); exp_o(3, 8'hD3, 1); exp_o(0, 8'hD4, 1);
        for (int i = 1; i <= 4; i++) recv_pkt(1, 8'hD0 + 8'(i));

        // p_in_tready toggling during a locked 4-beat packet while requester 0 waits.
        exp_in_pkt(1, 4, 8'h81, 8'h01);
        exp_i(0, 8'h90);
        bp_run = 1'b1;
        fork
            begin
                fork
                    send_pkt(1, 4, 8'h81, 8'h01);
                    begin repeat (2) @(posedge clk); #1; send_pkt(0, 1, 8'h90, 8'h00); end
                join
                bp_run = 1'b0;
            end
            while (bp_run) begin @(posedge clk); #1; p_in_tready = ~p_in_tready; end
        join
        p_in_tready = 1'b1;

        // Head requester holds m_axis_tready low; non-head readies must not leak through.
        m_axis_tready = 4'b1101;
        p_out_tvalid = 1'b1; p_out_tdata = 8'hE1; p_out_tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("obp_hold_%0d", i), {27'(0), p_out_tready, m_axis_tvalid}, {27'(0), 1'b0, 4'b0010});
            @(posedge clk);
        end
        #1;
        m_axis_tready = '1; p_out_tvalid = 1'b0; p_out_tlast = 1'b0;
        exp_o(1, 8'hE1, 1); exp_o(0, 8'hE2, 1);
        recv_pkt(1, 8'hE1);
        recv_pkt(1, 8'hE2);

        // Grant (push) in the same cycle as an output tlast pop.
        exp_i(1, 8'h61);
        send_pkt(1, 1, 8'h61, 8'h00);
        exp_o(1, 8'h71, 1); exp_i(2, 8'h62); exp_o(2, 8'h72, 1);
        s_axis_tvalid[2] = 1'b1; s_axis_tdata[2*IW +: IW] = 8'h62; s_axis_tlast[2] = 1'b1;
        p_out_tvalid = 1'b1; p_out_tdata = 8'h71; p_out_tlast = 1'b1;
        @(negedge clk);
        check("pp_route_old_head", {27'(0), p_out_tready, m_axis_tvalid}, {27'(0), 1'b1, 4'b0010});
        check("pp_idle_no_ready", 32'(s_axis_tready), 0);
        @(posedge clk); #1;
        p_out_tdata = 8'h72;
        @(negedge clk);
        check("pp_route_new_head", 32'(m_axis_tvalid), 32'b0100);
        check("pp_locked_ready", 32'(s_axis_tready), 32'b0100);
        @(posedge clk); #1;
        s_axis_tvalid[2] = 1'b0; s_axis_tlast[2] = 1'b0;
        p_out_tvalid = 1'b0; p_out_tlast = 1'b0;
        @(negedge clk);
        check("pp_fifo_empty_after", 32'(p_out_tready), 0);
        @(posedge clk); #1;

        // Reset on the 2nd beat of a 4-beat packet with a tag outstanding.
        mon_en = 1'b0;
        s_axis_tvalid[3] = 1'b1; s_axis_tdata[3*IW +: IW] = 8'hC0; s_axis_tlast[3] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_axis_tdata[3*IW +: IW] = 8'hC1;
        rst = 1'b1;
        p_out_tvalid = 1'b1; p_out_tdata = 8'h5C; p_out_tlast = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_s_tready", 32'(s_axis_tready), 0);
        check("mr_p_in_tvalid", 32'(p_in_tvalid), 0);
        check("mr_p_in_tdata", 32'(p_in_tdata), 0);
        check("mr_p_out_tready", 32'(p_out_tready), 0);
        check("mr_m_tvalid", 32'(m_axis_tvalid), 0);
        check("mr_m_tdata", 32'(m_axis_tdata), 0);
        check("mr_m_tlast", 32'(m_axis_tlast), 0);
        s_axis_tvalid[3] = 1'b0;
        p_out_tvalid = 1'b0; p_out_tlast = 1'b0;
        @(posedge clk); #1;
        exp_in.delete(); exp_out.delete();
        mon_en = 1'b1;
        exp_in_pkt(1, 3, 8'hA1, 8'h01);
        exp_out_pkt(1, 2, 8'hF1);
        send_pkt(1, 3, 8'hA1, 8'h01);
        recv_pkt(2, 8'hF1);
        @(negedge clk);
        check("mr_fifo_empty_after", 32'(p_out_tready), 0);

        repeat (2) @(posedge clk);
        check("sb_in_drained", 32'(exp_in.size()), 0);
        check("sb_out_drained", 32'(exp_out.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_processor_arbiter.md
# axis_processor_arbiter

Shares one AXI-Stream network processor among `N_REQ` independent requesters. Input packets (framed by `tlast`) are granted whole, one requester at a time, in round-robin order. Each grant's requester ID is queued in a tag FIFO, and processor output packets are routed back to requesters in that same order. The block sits between the host-side stream endpoints and a single processor instance (`network_source` → `network` → `network_sink`) plus its output framer.

## Interface

Reset is synchronous and active-high; clock and reset are `clk` and `rst`.

**Parameters**
- `N_REQ`, 4: number of requesters; legal range 2–16.
- `INP_WIDTH`, 8: processor input word width in bits.
- `OUT_WIDTH`, 8: processor output word width in bits.
- `TAG_DEPTH`, 4: tag FIFO depth, i.e. the maximum number of outstanding packets; must be a power of 2 and ≥ 2.

**Ports**
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `s_axis_tdata` input `N_REQ*INP_WIDTH`: requester input words; requester i occupies `[i*INP_WIDTH +: INP_WIDTH]`.
- `s_axis_tvalid` input `N_REQ`: per-requester input valid.
- `s_axis_tlast` input `N_REQ`: per-requester end of input packet.
- `s_axis_tready` output `N_REQ`: per-requester input ready.
- `p_in_tdata` output `INP_WIDTH`: word to processor input.
- `p_in_tvalid` output 1: valid to processor input.
- `p_in_tready` input 1: ready from processor input.
- `p_out_tdata` input `OUT_WIDTH`: word from processor output.
- `p_out_tvalid` input 1: valid from processor output.
- `p_out_tlast` input 1: end of output packet, supplied by the output framer.
- `p_out_tready` output 1: ready to processor output.
- `m_axis_tdata` output `OUT_WIDTH`: output word, broadcast to all requesters.
- `m_axis_tvalid` output `N_REQ`: per-requester output valid; at most one bit set.
- `m_axis_tlast` output 1: end of output packet, broadcast.
- `m_axis_tready` input `N_REQ`: per-requester output ready.

## Operation

**Input-side state machine**

States are IDLE and LOCKED; the grant index `g` is held in a register.
- **IDLE.** If any `s_axis_tvalid` is high and the tag FIFO is not full:
  - select the first valid requester at or after `rr_ptr` (cyclic search);
  - register the result as `g`;
  - push `g` into the tag FIFO;
  - move to LOCKED.
  - In IDLE, all `s_axis_tready` bits and `p_in_tvalid` are 0.
- **LOCKED.** Pure combinational pass-through with no added buffering:
  - `p_in_tdata = s_axis_tdata[g]`
  - `p_in_tvalid = s_axis_tvalid[g]`
  - `s_axis_tready[g] = p_in_tready`; all other `s_axis_tready` bits are 0.
- **End of packet.** A handshake with `s_axis_tlast[g]` high moves the machine to IDLE and sets `rr_ptr = (g+1) mod N_REQ`.
- **Dropped valid.** If a granted requester drops `tvalid` mid-packet, the grant holds; the lock ends only on `tlast`.

**Tag FIFO**
- Holds `TAG_DEPTH` entries of `$clog2(N_REQ)` bits, with an occupancy counter of `$clog2(TAG_DEPTH)+1` bits.
- Push and pop in the same cycle is legal: occupancy is unchanged and data order is preserved.
- A full FIFO blocks new grants. A packet already in LOCKED completes normally.

**Output-side routing**
- FIFO empty: `p_out_tready = 0` and all `m_axis_tvalid` bits are 0.
- FIFO non-empty, with head tag `h`:
  - `m_axis_tvalid[h] = p_out_tvalid`
  - `p_out_tready = m_axis_tready[h]`
  - `m_axis_tdata = p_out_tdata`
  - `m_axis_tlast = p_out_tlast`
- A handshake with `p_out_tlast` pops the FIFO. The next packet routes to the new head from the following cycle.
- `m_axis_tready` bits of non-head requesters are ignored.

## Timing

- **Reset values.** All of the following are 0 after reset:
  - `s_axis_tready`, `p_in_tvalid`, `p_out_tready`, `m_axis_tvalid`, `m_axis_tlast`;
  - `p_in_tdata` and `m_axis_tdata`;
  - state = IDLE, `rr_ptr` = 0, FIFO empty.
- **Grant latency.** 1 cycle: a valid that appears in cycle t is granted at the edge ending cycle t, and the first beat can transfer in cycle t+1.
- **Packet turnaround.** One IDLE cycle between consecutive input packets, so the minimum packet cost is length + 1 cycles.
- **Output path.** Zero-latency combinational routing; no bubble between output packets except the cycle the pop takes effect.
- **Mid-packet reset.** Reset asserted mid-packet aborts both packets immediately:
  - all state clears;
  - the processor is reset by the same `rst` from the upstream wrapper;
  - partial packets are discarded and are not replayed.

## Configuration

- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above, with `rr_ptr` updated at each end of packet.
- `ARB_ROUND_ROBIN_EN` undefined:
  - fixed priority, with the lowest-index valid requester winning;
  - `rr_ptr` logic is not synthesized.

## Test plan

- **Single packet.** `N_REQ=4`. Requester 2 sends the 3-beat packet 0x11, 0x22, 0x33 with tlast on the last beat.
  - `p_in` sees the same 3 beats starting one cycle after valid.
  - The processor returns 2 beats with tlast; only `m_axis_tvalid[2]` is asserted; the FIFO returns to empty.
- **Round-robin fairness.** Requesters 0–3 all continuously valid with 1-beat packets.
  - Grant order is 0, 1, 2, 3, 0, with one beat every 2 cycles.
  - Without `ARB_ROUND_ROBIN_EN`: requester 0 is always granted.
- **Full FIFO.** `TAG_DEPTH=4`, `p_out_tvalid` held at 0, requesters send 5 packets.
  - Exactly 4 are granted; the 5th requester sees `s_axis_tready` low.
  - After one output packet with tlast, the 5th is granted on the next cycle.
- **Backpressure.**
  - `p_in_tready` toggling 1/0 during a locked packet: no beat is lost or duplicated, and the lock holds until tlast.
  - `m_axis_tready[h]` held low for 5 cycles: `p_out_tready` stays low for those 5 cycles.
- **Simultaneous push and pop.** A new grant in the same cycle as an output tlast pop: occupancy is unchanged and routing order matches grant order.
- **Mid-packet reset.** `rst` asserted on the 2nd beat of a 4-beat packet: next cycle all outputs are 0 and state is IDLE; then a fresh packet from requester 1 completes correctly.
